// File: rtl/register_file_legv8.sv
// LEGv8 register file: 31 storage registers plus hard-wired XZR, two combinational
// read ports with write-through, and a registered NZCV status flag latch.
module register_file_legv8 #(
   parameter int WIDTH    = 64,
   parameter int ZERO_REG = 31
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [4:0]       SA,
   input  logic [4:0]       SB,
   input  logic [4:0]       DA,
   input  logic [WIDTH-1:0] D,
   input  logic             W,
   output logic [WIDTH-1:0] A,
   output logic [WIDTH-1:0] B,
   input  logic [3:0]       status_in,
   input  logic             SL,
   output logic [3:0]       status_out
);

   localparam logic [4:0] ZERO_ADDR = 5'(ZERO_REG);

   logic [31:0][WIDTH-1:0] rf_val;
   logic [3:0]             status_q;
   logic [3:0]             status_d;

   // XZR has no flop behind it; every other index gets its own storage register.
   for (genvar i = 0; i < 32; i++) begin : g_reg
      if (i == ZERO_REG) begin : g_zero
         assign rf_val[i] = '0;
      end else begin : g_store
         logic [WIDTH-1:0] reg_q;
         logic [WIDTH-1:0] reg_d;

         always_comb begin
            reg_d = reg_q;
            if (W && (DA == 5'(i))) begin
               reg_d = D;
            end
         end

         always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
               reg_q <= '0;
            end else begin
               reg_q <= reg_d;
            end
         end

         assign rf_val[i] = reg_q;
      end
   end

   // Write-through bypass applies even during reset; XZR always wins.
   always_comb begin
      A = rf_val[SA];
      if (SA == ZERO_ADDR) begin
         A = '0;
      end else if (W && (DA == SA)) begin
         A = D;
      end
   end

   always_comb begin
      B = rf_val[SB];
      if (SB == ZERO_ADDR) begin
         B = '0;
      end else if (W && (DA == SB)) begin
         B = D;
      end
   end

   always_comb begin
      status_d = status_q;
      if (SL) begin
         status_d = status_in;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         status_q <= 4'b0000;
      end else begin
         status_q <= status_d;
      end
   end

   assign status_out = status_q;

endmodule

// File: tb/tb_register_file_legv8.sv
// Scoreboard bench for register_file_legv8: stimulus queues expected A/B/status,
// a negedge monitor pops and compares against the live outputs.
module tb_register_file_legv8;

   localparam int WIDTH = 64;

   logic             clock;
   logic             reset_n;
   logic [4:0]       SA, SB, DA;
   logic [WIDTH-1:0] D;
   logic             W;
   logic [WIDTH-1:0] A, B;
   logic [3:0]       status_in;
   logic             SL;
   logic [3:0]       status_out;

   register_file_legv8 #(.WIDTH(WIDTH), .ZERO_REG(31)) dut (
      .clock(clock), .reset_n(reset_n),
      .SA(SA), .SB(SB), .DA(DA), .D(D), .W(W),
      .A(A), .B(B),
      .status_in(status_in), .SL(SL), .status_out(status_out)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      string            name;
      bit               chk_ab;
      logic [WIDTH-1:0] exp_a;
      logic [WIDTH-1:0] exp_b;
      logic [3:0]       exp_st;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   // Monitor: outputs are settled mid-cycle, so every queued expectation is checked at negedge.
   always @(negedge clock) begin
      exp_t e;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (e.chk_ab) begin
            n_checks++;
            if (A === e.exp_a) n_pass++;
            else $display("FAIL %s port A: got %h expected %h", e.name, A, e.exp_a);
            n_checks++;
            if (B === e.exp_b) n_pass++;
            else $display("FAIL %s port B: got %h expected %h", e.name, B, e.exp_b);
         end
         n_checks++;
         if (status_out === e.exp_st) n_pass++;
         else $display("FAIL %s status_out: got %b expected %b", e.name, status_out, e.exp_st);
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic expect_out(input string name, input bit chk_ab,
                             input logic [WIDTH-1:0] ea, input logic [WIDTH-1:0] eb,
                             input logic [3:0] est);
      exp_t e;
      e.name = name; e.chk_ab = chk_ab; e.exp_a = ea; e.exp_b = eb; e.exp_st = est;
      exp_q.push_back(e);
   endtask

   task automatic drive(input logic w, input logic [4:0] da, input logic [WIDTH-1:0] d,
                        input logic [4:0] sa, input logic [4:0] sb,
                        input logic sl, input logic [3:0] st);
      W = w; DA = da; D = d; SA = sa; SB = sb; SL = sl; status_in = st;
   endtask

   logic [WIDTH-1:0] m_rf [32];
   logic [3:0]       m_st;

   initial begin
      logic [WIDTH-1:0] ea, eb;
      reset_n = 1'b0;
      drive(0, 0, '0, 0, 0, 0, 4'b0000);

      // Reset state and full address sweep on both ports
      step();
      expect_out("reset_hold", 1, '0, '0, 4'b0000);
      step();
      reset_n = 1'b1;
      for (int i = 0; i < 32; i++) begin
         step();
         drive(0, 0, '0, 5'(i), 5'(31 - i), 0, 4'b0000);
         expect_out($sformatf("sweep_%0d", i), 1, '0, '0, 4'b0000);
      end

      // Write-through to X5 then stored value
      step();
      drive(1, 5, 64'hDEADBEEF_CAFEF00D, 5, 5, 0, 4'b0000);
      expect_out("wt_x5", 1, 64'hDEADBEEF_CAFEF00D, 64'hDEADBEEF_CAFEF00D, 4'b0000);
      step();
      drive(0, 5, '0, 5, 0, 0, 4'b0000);
      expect_out("stored_x5", 1, 64'hDEADBEEF_CAFEF00D, '0, 4'b0000);

      // XZR write is discarded, during and after
      step();
      drive(1, 31, 64'hFFFF_FFFF_FFFF_FFFF, 31, 31, 0, 4'b0000);
      expect_out("xzr_during", 1, '0, '0, 4'b0000);
      step();
      drive(0, 31, '0, 31, 31, 0, 4'b0000);
      expect_out("xzr_after", 1, '0, '0, 4'b0000);
      step();
      drive(0, 0, '0, 5, 31, 0, 4'b0000);
      expect_out("x5_survives", 1, 64'hDEADBEEF_CAFEF00D, '0, 4'b0000);

      // ADDS X1+X2 = 0x8000..01: V=0 C=0 N=1 Z=0 -> {V,C,N,Z}=0010
      step();
      drive(1, 1, 64'h1, 0, 0, 0, 4'b0000);
      step();
      drive(1, 2, 64'h8000_0000_0000_0000, 0, 0, 0, 4'b0000);
      step();
      drive(0, 0, '0, 1, 2, 1, 4'b0010);
      expect_out("alu_operands", 1, 64'h1, 64'h8000_0000_0000_0000, 4'b0000);
      step();
      drive(0, 0, '0, 1, 2, 0, 4'b1111);
      expect_out("flags_loaded", 1, 64'h1, 64'h8000_0000_0000_0000, 4'b0010);
      step();
      drive(0, 0, '0, 1, 2, 0, 4'b0101);
      expect_out("flags_hold", 0, '0, '0, 4'b0010);

      // Same-edge register write and flag load
      step();
      drive(1, 9, 64'h55, 0, 0, 1, 4'b1001);
      step();
      drive(0, 0, '0, 9, 9, 0, 4'b0000);
      expect_out("w_and_sl", 1, 64'h55, 64'h55, 4'b1001);

      // Asynchronous reset between edges
      step();
      drive(1, 7, 64'h1234, 0, 0, 0, 4'b0000);
      step();
      drive(0, 0, '0, 7, 7, 0, 4'b0000);
      expect_out("x7_written", 1, 64'h1234, 64'h1234, 4'b1001);
      step();
      drive(0, 0, '0, 7, 9, 0, 4'b0000);
      #2;
      reset_n = 1'b0;
      expect_out("async_reset", 1, '0, '0, 4'b0000);
      // Writes and flag loads ignored under reset; write-through still visible
      step();
      drive(1, 7, 64'hABCD, 8, 7, 1, 4'b1111);
      expect_out("reset_wt", 1, '0, 64'hABCD, 4'b0000);
      step();
      drive(0, 0, '0, 7, 8, 0, 4'b0000);
      expect_out("reset_no_write", 1, '0, '0, 4'b0000);
      // First write lands on the first edge after deassertion
      step();
      reset_n = 1'b1;
      drive(1, 3, 64'hAA, 0, 0, 1, 4'b0100);
      step();
      drive(0, 0, '0, 3, 7, 0, 4'b0000);
      expect_out("post_reset_write", 1, 64'hAA, '0, 4'b0100);

      // Random phase against a behavioural model, starting from a fresh reset
      step();
      reset_n = 1'b0;
      drive(0, 0, '0, 0, 0, 0, 4'b0000);
      #1;
      reset_n = 1'b1;
      for (int i = 0; i < 32; i++) m_rf[i] = '0;
      m_st = 4'b0000;
      for (int n = 0; n < 2000; n++) begin
         logic             w, sl;
         logic [4:0]       da, sa, sb;
         logic [WIDTH-1:0] d;
         logic [3:0]       st;
         step();
         w  = 1'($urandom);
         sl = 1'($urandom);
         sa = 5'($urandom);
         sb = ($urandom_range(0, 3) == 0) ? sa : 5'($urandom);
         da = ($urandom_range(0, 3) == 0) ? sa : 5'($urandom);
         d  = {$urandom, $urandom};
         st = 4'($urandom);
         drive(w, da, d, sa, sb, sl, st);
         ea = (sa == 31) ? '0 : ((w && da == sa) ? d : m_rf[sa]);
         eb = (sb == 31) ? '0 : ((w && da == sb) ? d : m_rf[sb]);
         expect_out($sformatf("rand_%0d", n), 1, ea, eb, m_st);
         if (w && da != 31) m_rf[da] = d;
         if (sl) m_st = st;
      end

      @(negedge clock);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
